// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic PE.
// Optional build macro used by pe_mac_unit: SYSTOLIC_PE_SATURATE_EN.
package systolic_pkg;

   // Drain-chain FSM states
   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      FWD
   } pe_state_t;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ACC_W  = 20;

   // Largest signed value representable in acc_w bits (acc_w <= 64)
   function automatic logic signed [63:0] sat_max(input int unsigned acc_w);
      return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
   endfunction

   // Smallest signed value representable in acc_w bits (acc_w <= 64)
   function automatic logic signed [63:0] sat_min(input int unsigned acc_w);
      return -(64'sd1 <<< (acc_w - 1));
   endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational signed multiply-add with overflow detection.
// Build macro SYSTOLIC_PE_SATURATE_EN: clamp the sum on overflow instead of wrapping.
module pe_mac_unit
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ACC_W  = DEF_ACC_W
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  sum,
   output logic                     ovf
);

`ifdef SYSTOLIC_PE_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));
`endif

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    raw;

   // Full-precision product, sign-extended add, overflow from operand/result signs
   always_comb begin
      prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
      prod_ext = ACC_W'(prod);
      raw      = acc + prod_ext;
      ovf      = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
      sum      = raw;
`ifdef SYSTOLIC_PE_SATURATE_EN
      if (ovf) begin
         sum = acc[ACC_W-1] ? SAT_MIN : SAT_MAX;
      end
`endif
   end

endmodule

// File: rtl/systolic_pe_os.sv
// Output-stationary systolic PE: forwards A east and B south, accumulates
// A*B locally, and unloads onto a per-column partial-sum drain chain.
// Build macro SYSTOLIC_PE_SATURATE_EN selects saturating accumulation.
// ACC_W must be at least 2*DATA_W.
module systolic_pe_os
   import systolic_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned ACC_W     = DEF_ACC_W,
   parameter int unsigned CHAIN_POS = 0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic signed [DATA_W-1:0] a_in,
   input  logic                     a_valid_in,
   input  logic signed [DATA_W-1:0] b_in,
   input  logic                     b_valid_in,
   output logic signed [DATA_W-1:0] a_out,
   output logic                     a_valid_out,
   output logic signed [DATA_W-1:0] b_out,
   output logic                     b_valid_out,
   input  logic                     clear_acc,
   input  logic                     drain_in,
   input  logic signed [ACC_W-1:0]  psum_in,
   input  logic                     psum_valid_in,
   output logic signed [ACC_W-1:0]  psum_out,
   output logic                     psum_valid_out,
   output logic                     busy,
   output logic                     acc_ovf
);

   localparam int unsigned CNT_W = (CHAIN_POS > 0) ? $clog2(CHAIN_POS + 1) : 1;

   pe_state_t               state;
   logic [CNT_W-1:0]        fwd_cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] mac_sum;
   logic                    mac_ovf;
   logic                    mac_fire;
   logic                    capture;
   logic                    clr;

   assign mac_fire = a_valid_in & b_valid_in;
   assign capture  = (state == IDLE) & drain_in;
   assign clr      = clear_acc | capture;
   // Clear takes effect before this cycle's product is added
   assign base     = clr ? '0 : acc;
   assign busy     = (state != IDLE);

   pe_mac_unit #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .acc (base),
      .a   (a_in),
      .b   (b_in),
      .sum (mac_sum),
      .ovf (mac_ovf)
   );

   // Operand pipeline: unconditional one-cycle delay to the neighbours
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_out       <= '0;
         a_valid_out <= 1'b0;
         b_out       <= '0;
         b_valid_out <= 1'b0;
      end else begin
         a_out       <= a_in;
         a_valid_out <= a_valid_in;
         b_out       <= b_in;
         b_valid_out <= b_valid_in;
      end
   end

   // Accumulator and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc     <= '0;
         acc_ovf <= 1'b0;
      end else begin
         acc     <= mac_fire ? mac_sum : base;
         acc_ovf <= (acc_ovf & ~clr) | (mac_fire & mac_ovf);
      end
   end

   // Drain FSM: emit own result, then forward CHAIN_POS valid upstream beats
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         fwd_cnt        <= '0;
         psum_out       <= '0;
         psum_valid_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (drain_in) begin
                  psum_out       <= acc;
                  psum_valid_out <= 1'b1;
                  state          <= EMIT;
               end else begin
                  psum_valid_out <= 1'b0;
               end
            end
            EMIT: begin
               psum_valid_out <= 1'b0;
               if (CHAIN_POS == 0) begin
                  state <= IDLE;
               end else begin
                  state   <= FWD;
                  fwd_cnt <= CNT_W'(CHAIN_POS);
               end
            end
            FWD: begin
               psum_out       <= psum_in;
               psum_valid_out <= psum_valid_in;
               if (psum_valid_in) begin
                  fwd_cnt <= fwd_cnt - 1'b1;
                  if (fwd_cnt == CNT_W'(1)) begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state          <= IDLE;
               psum_valid_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_pe_os.sv
// Self-checking bench for systolic_pe_os (DATA_W=8, ACC_W=20, CHAIN_POS=2).
// Expected values come from an integer reference model of the accumulator.
module tb_systolic_pe_os;

   localparam longint MAXV = 524287;
   localparam longint MINV = -524288;
   localparam longint MODV = 1048576;

   logic               clk = 1'b0;
   logic               reset_n;
   logic signed [7:0]  a_in, b_in, a_out, b_out;
   logic               a_valid_in, b_valid_in, a_valid_out, b_valid_out;
   logic               clear_acc, drain_in;
   logic signed [19:0] psum_in, psum_out;
   logic               psum_valid_in, psum_valid_out;
   logic               busy, acc_ovf;

   longint             m_acc;
   bit                 m_ovf, m_busy;
   logic signed [7:0]  e_a, e_b;
   logic               e_av, e_bv;
   int                 n_checks = 0;
   int                 n_errors = 0;

   systolic_pe_os #(
      .DATA_W    (8),
      .ACC_W     (20),
      .CHAIN_POS (2)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .a_in           (a_in),
      .a_valid_in     (a_valid_in),
      .b_in           (b_in),
      .b_valid_in     (b_valid_in),
      .a_out          (a_out),
      .a_valid_out    (a_valid_out),
      .b_out          (b_out),
      .b_valid_out    (b_valid_out),
      .clear_acc      (clear_acc),
      .drain_in       (drain_in),
      .psum_in        (psum_in),
      .psum_valid_in  (psum_valid_in),
      .psum_out       (psum_out),
      .psum_valid_out (psum_valid_out),
      .busy           (busy),
      .acc_ovf        (acc_ovf)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_psum(input string tag, input longint exp);
      logic [19:0] e;
      e = exp[19:0];
      chk(tag, {44'b0, psum_out}, {44'b0, e});
   endtask

   // One clock: update the model from the current inputs, then check the
   // pipeline, busy and overflow outputs just after the edge.
   task automatic cycle(input bit busy_after);
      longint s, base;
      bit     clr, ov;
      e_a  = a_in;
      e_b  = b_in;
      e_av = a_valid_in;
      e_bv = b_valid_in;
      if (!reset_n) begin
         m_acc = 0;
         m_ovf = 0;
         e_a   = '0;
         e_b   = '0;
         e_av  = 1'b0;
         e_bv  = 1'b0;
      end else begin
         clr  = clear_acc || (drain_in && !m_busy);
         base = clr ? 0 : m_acc;
         ov   = 0;
         if (a_valid_in && b_valid_in) begin
            s = base + longint'(a_in) * longint'(b_in);
            if (s > MAXV || s < MINV) begin
               ov = 1;
`ifdef SYSTOLIC_PE_SATURATE_EN
               s = (s > MAXV) ? MAXV : MINV;
`else
               s = (s > MAXV) ? s - MODV : s + MODV;
`endif
            end
            m_acc = s;
         end else begin
            m_acc = base;
         end
         m_ovf = (m_ovf && !clr) || ov;
      end
      @(posedge clk);
      #1;
      m_busy = busy_after;
      chk("a_out", {56'b0, a_out}, {56'b0, e_a});
      chk("a_valid_out", {63'b0, a_valid_out}, {63'b0, e_av});
      chk("b_out", {56'b0, b_out}, {56'b0, e_b});
      chk("b_valid_out", {63'b0, b_valid_out}, {63'b0, e_bv});
      chk("busy", {63'b0, busy}, {63'b0, m_busy});
      chk("acc_ovf", {63'b0, acc_ovf}, {63'b0, m_ovf});
   endtask

   // Full unload: own value, then two upstream beats separated by an idle
   // beat during which a second drain_in pulse must be ignored.
   task automatic do_drain(input longint exp_own);
      logic signed [19:0] r1, r2;
      r1 = 20'($urandom);
      r2 = 20'($urandom);
      drain_in = 1'b1;
      cycle(1);
      drain_in   = 1'b0;
      a_valid_in = 1'b0;
      b_valid_in = 1'b0;
      chk_psum("drain_own", exp_own);
      chk("drain_own_valid", {63'b0, psum_valid_out}, 64'd1);
      cycle(1);
      chk("emit_done_valid", {63'b0, psum_valid_out}, 64'd0);
      chk_psum("emit_hold", exp_own);
      psum_in       = r1;
      psum_valid_in = 1'b1;
      cycle(1);
      chk_psum("fwd_first", longint'(r1));
      chk("fwd_first_valid", {63'b0, psum_valid_out}, 64'd1);
      psum_valid_in = 1'b0;
      psum_in       = 20'($urandom);
      drain_in      = 1'b1;
      cycle(1);
      drain_in = 1'b0;
      chk("fwd_gap_valid", {63'b0, psum_valid_out}, 64'd0);
      psum_in       = r2;
      psum_valid_in = 1'b1;
      cycle(0);
      chk_psum("fwd_last", longint'(r2));
      chk("fwd_last_valid", {63'b0, psum_valid_out}, 64'd1);
      psum_valid_in = 1'b0;
      cycle(0);
      chk("idle_valid", {63'b0, psum_valid_out}, 64'd0);
      chk_psum("idle_hold", longint'(r2));
   endtask

   initial begin
      reset_n       = 1'b0;
      a_in          = 8'sd5;
      b_in          = -8'sd3;
      a_valid_in    = 1'b1;
      b_valid_in    = 1'b1;
      clear_acc     = 1'b0;
      drain_in      = 1'b1;
      psum_in       = 20'sd77;
      psum_valid_in = 1'b1;
      m_acc         = 0;
      m_ovf         = 0;
      m_busy        = 0;

      // Reset state
      cycle(0);
      cycle(0);
      chk_psum("reset_psum", 0);
      chk("reset_psum_valid", {63'b0, psum_valid_out}, 64'd0);
      reset_n       = 1'b1;
      drain_in      = 1'b0;
      psum_valid_in = 1'b0;
      a_valid_in    = 1'b0;
      b_valid_in    = 1'b0;
      cycle(0);

      // Pass-through of extreme operands
      a_in       = 8'sh7F;
      b_in       = 8'sh80;
      a_valid_in = 1'b1;
      b_valid_in = 1'b1;
      cycle(0);
      chk("pass_a", {56'b0, a_out}, 64'h7F);
      chk("pass_b", {56'b0, b_out}, 64'h80);
      a_valid_in = 1'b0;
      b_valid_in = 1'b0;
      cycle(0);
      chk("pass_a_valid_drop", {63'b0, a_valid_out}, 64'd0);

      // Accumulate three pairs then drain
      clear_acc = 1'b1;
      cycle(0);
      clear_acc  = 1'b0;
      a_valid_in = 1'b1;
      b_valid_in = 1'b1;
      a_in = 8'sd3;  b_in = 8'sd4;  cycle(0);
      a_in = -8'sd2; b_in = 8'sd5;  cycle(0);
      a_in = 8'sd7;  b_in = -8'sd1; cycle(0);
      a_valid_in = 1'b0;
      b_valid_in = 1'b0;
      do_drain(-5);
      do_drain(0);

      // Clear with MAC loads 10; drain overlapping a MAC leaves 6
      clear_acc  = 1'b1;
      a_in       = 8'sd2;
      b_in       = 8'sd5;
      a_valid_in = 1'b1;
      b_valid_in = 1'b1;
      cycle(0);
      clear_acc = 1'b0;
      b_in      = 8'sd3;
      do_drain(10);
      do_drain(6);

      // Randomised accumulate/clear runs, drained with MAC overlap
      for (int r = 0; r < 6; r++) begin
         int n;
         n = int'($urandom_range(3, 30));
         for (int i = 0; i < n; i++) begin
            a_in       = 8'($urandom);
            b_in       = 8'($urandom);
            a_valid_in = ($urandom_range(0, 3) != 0);
            b_valid_in = ($urandom_range(0, 3) != 0);
            clear_acc  = ($urandom_range(0, 15) == 0);
            cycle(0);
         end
         clear_acc  = 1'b0;
         a_in       = 8'($urandom);
         b_in       = 8'($urandom);
         a_valid_in = $urandom_range(0, 1) != 0;
         b_valid_in = 1'b1;
         do_drain(m_acc);
      end
      do_drain(m_acc);

      // Overflow: 40 x (-128)*(-128) from zero
      clear_acc = 1'b1;
      cycle(0);
      clear_acc  = 1'b0;
      a_in       = -8'sd128;
      b_in       = -8'sd128;
      a_valid_in = 1'b1;
      b_valid_in = 1'b1;
      for (int i = 0; i < 40; i++) cycle(0);
      a_valid_in = 1'b0;
      b_valid_in = 1'b0;
      chk("ovf_sticky", {63'b0, acc_ovf}, 64'd1);
`ifdef SYSTOLIC_PE_SATURATE_EN
      do_drain(524287);
`else
      do_drain(-393216);
`endif
      chk("ovf_cleared", {63'b0, acc_ovf}, 64'd0);

      // Reset in the middle of forwarding
      a_in       = 8'sd9;
      b_in       = 8'sd9;
      a_valid_in = 1'b1;
      b_valid_in = 1'b1;
      cycle(0);
      a_valid_in = 1'b0;
      b_valid_in = 1'b0;
      drain_in   = 1'b1;
      cycle(1);
      drain_in = 1'b0;
      cycle(1);
      psum_in       = 20'sd1234;
      psum_valid_in = 1'b1;
      cycle(1);
      reset_n    = 1'b0;
      a_valid_in = 1'b1;
      b_valid_in = 1'b1;
      cycle(0);
      chk_psum("midreset_psum", 0);
      chk("midreset_psum_valid", {63'b0, psum_valid_out}, 64'd0);
      reset_n       = 1'b1;
      a_valid_in    = 1'b0;
      b_valid_in    = 1'b0;
      psum_valid_in = 1'b0;
      do_drain(0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
